bcd_comp_serial: RTL and testbench

Parametrised, digit-serial BCD complementer: N-digit successor to the single-digit combinational BCD 9's-complement block.
- Computes the 9's or 10's complement of a packed BCD word, one digit per clock, least-significant digit first.
- Uses a start/busy/done handshake.
- Flags invalid BCD digits.
- Feeds the lab's BCD subtractor datapath: A − B = A + 10's complement of B.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_comp_serial_if.sv | 13 +
 rtl/bcd_digit_comp.sv | 18 +
 rtl/bcd_comp_serial.sv | 57 +++++
 tb/tb_bcd_comp_serial.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD complementer family
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  localparam logic MODE_9C = 1'b0;
  localparam logic MODE_10C = 1'b1;
endpackage

// File: rtl/bcd_comp_serial_if.sv
// bcd_comp_serial_if: start/busy/done handshake and data bus of the serial complementer
interface bcd_comp_serial_if #(parameter int DIGITS = 4);
  logic start;
  logic mode;
  logic [4*DIGITS-1:0] bcd_in;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] comp_out;
  logic cout;
  logic err;
  modport master (output start, mode, bcd_in, input busy, done, comp_out, cout, err);
  modport slave (input start, mode, bcd_in, output busy, done, comp_out, cout, err);
endinterface

// File: rtl/bcd_digit_comp.sv
// bcd_digit_comp: single-digit 9's complement plus carry-in, flags digits above 9
module bcd_digit_comp
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout,
  output logic       inv
);
  logic [4:0] s;
  always_comb begin
    inv = d > BCD_MAX;
    s = {1'b0, BCD_MAX - d} + {4'd0, cin};
    cout = !inv && s == 5'd10;
    q = inv ? BCD_INVALID : cout ? 4'd0 : s[3:0];
  end
endmodule

// File: rtl/bcd_comp_serial.sv
// bcd_comp_serial: digit-serial 9's/10's complement of a packed BCD word, LSD first
module bcd_comp_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_comp_serial_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  state_t state, next;
  logic [4*DIGITS-1:0] op, comp;
  logic [IW-1:0] idx;
  logic carry, cout_r, err_r;
  logic [3:0] d, q;
  logic dc, inv;
  assign d = op[4*idx +: 4];
  bcd_digit_comp u_dig (.d(d), .cin(carry), .q(q), .cout(dc), .inv(inv));
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb
    next = state == IDLE ? (bus.start ? RUN : IDLE) :
           state == RUN  ? (idx == LAST ? DONE : RUN) : IDLE;
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
    bus.comp_out = comp;
    bus.cout = cout_r;
    bus.err = err_r;
  end
  // the 10's complement is the 9's complement with the mode bit as initial carry-in
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0;
      comp <= '0;
      idx <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
      err_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      op <= bus.bcd_in;
      comp <= '0;
      idx <= '0;
      carry <= bus.mode == MODE_10C;
      cout_r <= 1'b0;
      err_r <= 1'b0;
    end else if (state == RUN) begin
      comp[4*idx +: 4] <= q;
      carry <= dc;
      err_r <= err_r | inv;
      if (idx == LAST) cout_r <= dc;
      else idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_comp_serial.sv
// tb_bcd_comp_serial: directed self-checking bench for the serial BCD complementer
module tb_bcd_comp_serial;
  import bcd_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bcd_comp_serial_if #(.DIGITS(4)) b4 ();
  bcd_comp_serial_if #(.DIGITS(1)) b1 ();
  bcd_comp_serial #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  bcd_comp_serial #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic run_op(input logic m, input logic [15:0] v, output int busy_n, output bit got_done);
    @(negedge clk);
    b4.start = 1'b1; b4.mode = m; b4.bcd_in = v;
    @(negedge clk);
    b4.start = 1'b0;
    busy_n = 0; got_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (b4.done) begin got_done = 1; break; end
      if (b4.busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_op(input string name, input logic m, input logic [15:0] v,
                         input logic [15:0] exp_q, input logic exp_c, input logic exp_e);
    int bn; bit gd;
    run_op(m, v, bn, gd);
    n_tests++; if (!gd) begin n_fail++; $display("FAIL %s done: not seen, required 1", name); end
    n_tests++; if (bn !== 4) begin n_fail++; $display("FAIL %s busy_cycles: got %0d, required 4", name, bn); end
    n_tests++; if (b4.comp_out !== exp_q) begin n_fail++; $display("FAIL %s comp_out: got %h, required %h", name, b4.comp_out, exp_q); end
    n_tests++; if (b4.cout !== exp_c) begin n_fail++; $display("FAIL %s cout: got %b, required %b", name, b4.cout, exp_c); end
    n_tests++; if (b4.err !== exp_e) begin n_fail++; $display("FAIL %s err: got %b, required %b", name, b4.err, exp_e); end
    @(negedge clk);
    n_tests++; if (b4.done !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got 1, required 0", name); end
    n_tests++; if (b4.comp_out !== exp_q) begin n_fail++; $display("FAIL %s hold: got %h, required %h", name, b4.comp_out, exp_q); end
  endtask

  task automatic test_reset;
    rst = 1'b1; b4.start = 1'b1; b4.mode = 1'b1; b4.bcd_in = 16'h1234;
    b1.start = 1'b0; b1.mode = 1'b0; b1.bcd_in = 4'h0;
    repeat (2) @(negedge clk);
    n_tests++; if ({b4.busy, b4.done, b4.cout, b4.err} !== 4'b0) begin n_fail++; $display("FAIL reset flags: got %b, required 0000", {b4.busy, b4.done, b4.cout, b4.err}); end
    n_tests++; if (b4.comp_out !== 16'h0) begin n_fail++; $display("FAIL reset comp_out: got %h, required 0000", b4.comp_out); end
    rst = 1'b0; b4.start = 1'b0;
    @(negedge clk);
    n_tests++; if (b4.busy !== 1'b0) begin n_fail++; $display("FAIL reset no_accept: busy %b, required 0", b4.busy); end
  endtask

  task automatic test_nines;
    test_op("nines_1234", MODE_9C, 16'h1234, 16'h8765, 1'b0, 1'b0);
    test_op("nines_0000", MODE_9C, 16'h0000, 16'h9999, 1'b0, 1'b0);
  endtask

  task automatic test_tens;
    test_op("tens_1234", MODE_10C, 16'h1234, 16'h8766, 1'b0, 1'b0);
    test_op("tens_0000", MODE_10C, 16'h0000, 16'h0000, 1'b1, 1'b0);
    test_op("tens_0990", MODE_10C, 16'h0990, 16'h9010, 1'b0, 1'b0);
  endtask

  task automatic test_invalid;
    test_op("inv_12A4", MODE_10C, 16'h12A4, 16'h87F6, 1'b0, 1'b1);
    test_op("inv_clear", MODE_10C, 16'h1234, 16'h8766, 1'b0, 1'b0);
  endtask

  task automatic test_abuse;
    int dn = 0; bit gd = 0;
    @(negedge clk);
    b4.start = 1'b1; b4.mode = MODE_9C; b4.bcd_in = 16'h1234;
    @(negedge clk);
    b4.start = 1'b0;
    @(negedge clk);
    b4.start = 1'b1; b4.mode = MODE_10C; b4.bcd_in = 16'h5555;
    @(negedge clk);
    b4.start = 1'b0;
    for (int i = 0; i < 10 && !gd; i++) begin
      if (b4.done) gd = 1;
      else @(negedge clk);
    end
    n_tests++; if (!gd) begin n_fail++; $display("FAIL abuse done: not seen, required 1"); end
    n_tests++; if (b4.comp_out !== 16'h8765) begin n_fail++; $display("FAIL abuse comp_out: got %h, required 8765", b4.comp_out); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b4.done || b4.busy) dn++;
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL abuse queued: %0d active cycles, required 0", dn); end
  endtask

  task automatic test_back_to_back;
    int dn = 0, first = -1, second = -1;
    bit bad = 0;
    @(negedge clk);
    b4.start = 1'b1; b4.mode = MODE_10C; b4.bcd_in = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b4.done) begin
        dn++;
        if (first < 0) first = i; else if (second < 0) second = i;
        if (b4.comp_out !== 16'h9999) bad = 1;
      end
    end
    b4.start = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++; if (dn !== 3) begin n_fail++; $display("FAIL b2b done_count: got %0d, required 3", dn); end
    n_tests++; if (second - first !== 6) begin n_fail++; $display("FAIL b2b period: got %0d, required 6", second - first); end
    n_tests++; if (bad) begin n_fail++; $display("FAIL b2b comp_out: got wrong value, required 9999"); end
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    @(negedge clk);
    b4.start = 1'b1; b4.mode = MODE_10C; b4.bcd_in = 16'h12A4;
    @(negedge clk);
    b4.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (b4.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b, required 0", b4.busy); end
    n_tests++; if ({b4.comp_out, b4.cout, b4.err} !== 18'h0) begin n_fail++; $display("FAIL rst_mid outputs: got %h/%b/%b, required 0", b4.comp_out, b4.cout, b4.err); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b4.done) dn++;
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rst_mid done: got %0d pulses, required 0", dn); end
    test_op("rst_mid_after", MODE_10C, 16'h0990, 16'h9010, 1'b0, 1'b0);
  endtask

  task automatic test_exhaustive;
    logic [3:0] eq; logic ec, ee; bit gd;
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 16; d++) begin
        ee = d > 9;
        ec = m == 1 && d == 0;
        eq = ee ? 4'hF : m == 0 ? 4'(9 - d) : 4'((10 - d) % 10);
        @(negedge clk);
        b1.start = 1'b1; b1.mode = m[0]; b1.bcd_in = 4'(d);
        @(negedge clk);
        b1.start = 1'b0;
        gd = 0;
        for (int i = 0; i < 6 && !gd; i++) begin
          if (b1.done) gd = 1;
          else @(negedge clk);
        end
        n_tests++;
        if (!gd || b1.comp_out !== eq || b1.cout !== ec || b1.err !== ee) begin
          n_fail++;
          $display("FAIL exh m=%0d d=%0d: got done=%b q=%h c=%b e=%b, required q=%h c=%b e=%b",
                   m, d, gd, b1.comp_out, b1.cout, b1.err, eq, ec, ee);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_nines;
    test_tens;
    test_invalid;
    test_abuse;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
